// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uartout byte arbiter (uart_arb) and its
// round-robin picker (rr_pick).
//   state_t  : arbiter FSM states, also exported on uart_arb.dbg_state
//   NREQ_MAX : largest supported number of requesters
//   PTR_W    : width of a requester index / last-winner pointer
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int NREQ_MAX = 4;
    localparam int PTR_W    = $clog2(NREQ_MAX);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection. The search starts at
// (last + 1) mod NREQ and wraps, so the previous winner has lowest priority.
// Ports:
//   req   in  NREQ   active-high request vector
//   last  in  PTR_W  index of the previous winner
//   grant out NREQ   one-hot grant (all zero when nobody requests)
//   valid out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] last,
    output logic [NREQ-1:0]  grant,
    output logic             valid
);

    // Outer loop walks priority order; inner loop maps the rotated position
    // onto a constant bit index so no variable-width select is needed.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!valid && req[j] && (((int'(last) + i) % NREQ) == j)) begin
                    grant[j] = 1'b1;
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_arb.sv
// -----------------------------------------------------------------------------
// uart_arb
// Shares one uartout transmitter between NREQ byte requesters. A winner is
// picked round-robin in IDLE, its byte is latched and launched with a single
// low strobe on tx_n_cs (together with the winner's n_ack), then the FSM
// follows tx_n_rd through busy and back to idle before the next launch.
//
// Handshake: a requester holds n_req[i] low with a stable byte until it sees
// a one-cycle low pulse on n_ack[i]; that pulse coincides with the tx_n_cs
// launch strobe, which is the only cycle the byte is handed to uartout.
//
// Parameters:
//   NREQ     number of requesters (2..4)
//   WAIT_MAX cycles allowed for tx_n_rd to go high after a launch
// Ports:
//   clk       in   1       system clock, rising edge
//   n_rst     in   1       asynchronous active-low reset
//   n_req     in   NREQ    active-low byte requests
//   req_data  in   8*NREQ  byte of requester i at [8i+7:8i]
//   n_lock    in   NREQ    active-low lock (only with UART_ARB_LOCK_EN)
//   n_ack     out  NREQ    active-low one-cycle ack pulse
//   tx_n_cs   out  1       active-low one-cycle launch strobe
//   tx_data   out  8       registered byte for uartout
//   tx_n_rd   in   1       low = transmitter idle, high = frame in progress
//   err       out  1       one-cycle pulse when the transmitter never went busy
//   dbg_state out  2       current FSM state
// Build option: define UART_ARB_LOCK_EN to add the n_lock port.
// -----------------------------------------------------------------------------
module uart_arb
    import uart_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int WAIT_MAX = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NREQ-1:0]     n_req,
    input  logic [8*NREQ-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NREQ-1:0]     n_lock,
`endif
    output logic [NREQ-1:0]     n_ack,
    output logic                tx_n_cs,
    output logic [7:0]          tx_data,
    input  logic                tx_n_rd,
    output logic                err,
    output state_t              dbg_state
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_t             state;
    logic [PTR_W-1:0]   last;
    logic [PTR_W-1:0]   win;
    logic [CNT_W-1:0]   cnt;

    logic [NREQ-1:0]    req_vec;
    logic [NREQ-1:0]    grant;
    logic               grant_vld;
    logic [7:0]         grant_byte;
    logic [PTR_W-1:0]   grant_idx;

    assign dbg_state = state;

`ifdef UART_ARB_LOCK_EN
    // While the previous winner keeps its lock low, nobody else may win,
    // even in cycles where that requester has no byte pending.
    logic [NREQ-1:0] last_oh;
    logic            locked;

    always_comb begin
        last_oh = '0;
        for (int j = 0; j < NREQ; j++) begin
            last_oh[j] = (int'(last) == j);
        end
        locked  = |(last_oh & ~n_lock);
        req_vec = locked ? (~n_req & last_oh) : ~n_req;
    end
`else
    assign req_vec = ~n_req;
`endif

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req_vec),
        .last  (last),
        .grant (grant),
        .valid (grant_vld)
    );

    // One-hot grant to byte and index.
    always_comb begin
        grant_byte = '0;
        grant_idx  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant[j]) begin
                grant_byte = grant_byte | req_data[8*j +: 8];
                grant_idx  = PTR_W'(j);
            end
        end
    end

    // Strobes and err default to inactive every cycle, which makes them
    // single-cycle pulses without extra clearing logic.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            n_ack   <= '1;
            tx_n_cs <= 1'b1;
            tx_data <= 8'h00;
            err     <= 1'b0;
            last    <= PTR_W'(NREQ - 1);
            win     <= '0;
            cnt     <= '0;
        end else begin
            n_ack   <= '1;
            tx_n_cs <= 1'b1;
            err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!tx_n_rd && grant_vld) begin
                        tx_data <= grant_byte;
                        win     <= grant_idx;
                        n_ack   <= ~grant;
                        tx_n_cs <= 1'b0;
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    last  <= win;
                    cnt   <= '0;
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_n_rd) begin
                        state <= ST_WAIT_DONE;
                    end else if (cnt == CNT_W'(WAIT_MAX - 1)) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else if (cnt != CNT_W'(WAIT_MAX)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_n_rd) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_arb
// Directed bench for uart_arb (NREQ=2, WAIT_MAX=16). The bench plays the
// uartout transmitter by driving tx_n_rd, and checks launches, acks, bytes,
// timeout and reset behaviour against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_arb;
    import uart_pkg::*;

    localparam int NREQ     = 2;
    localparam int WAIT_MAX = 16;

    logic                clk      = 1'b0;
    logic                n_rst    = 1'b0;
    logic [NREQ-1:0]     n_req    = '1;
    logic [8*NREQ-1:0]   req_data = '0;
    logic [NREQ-1:0]     n_ack;
    logic                tx_n_cs;
    logic [7:0]          tx_data;
    logic                tx_n_rd  = 1'b0;
    logic                err;
    state_t              dbg_state;
`ifdef UART_ARB_LOCK_EN
    logic [NREQ-1:0]     n_lock   = '1;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    uart_arb #(
        .NREQ     (NREQ),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .n_req     (n_req),
        .req_data  (req_data),
`ifdef UART_ARB_LOCK_EN
        .n_lock    (n_lock),
`endif
        .n_ack     (n_ack),
        .tx_n_cs   (tx_n_cs),
        .tx_data   (tx_data),
        .tx_n_rd   (tx_n_rd),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        n_rst   = 1'b0;
        n_req   = '1;
        tx_n_rd = 1'b0;
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
    endtask

    // Called while the DUT shows LAUNCH: plays one short transmitter frame
    // and leaves the DUT back in IDLE.
    task automatic finish_frame;
        tick();
        tx_n_rd = 1'b1;
        tick();
        tx_n_rd = 1'b0;
        tick();
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_n_cs === 1'b0) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        n_rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (tx_n_cs !== 1'b1) begin n_fail++; $display("FAIL reset_tx_n_cs: got %b want 1", tx_n_cs); end
        n_cmp++; if (n_ack !== 2'b11) begin n_fail++; $display("FAIL reset_n_ack: got %b want 11", n_ack); end
        n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_single;
        req_data = {8'h00, 8'h41};
        n_req    = 2'b10;
        tx_n_rd  = 1'b0;
        tick();
        n_cmp++; if (tx_n_cs !== 1'b0) begin n_fail++; $display("FAIL single_strobe: got %b want 0", tx_n_cs); end
        n_cmp++; if (n_ack !== 2'b10) begin n_fail++; $display("FAIL single_ack: got %b want 10", n_ack); end
        n_cmp++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h want 41", tx_data); end
        n_req = 2'b11;
        tick();
        n_cmp++; if (tx_n_cs !== 1'b1 || n_ack !== 2'b11) begin n_fail++; $display("FAIL single_pulse_len: got cs=%b ack=%b want cs=1 ack=11", tx_n_cs, n_ack); end
        n_cmp++; if (dbg_state !== ST_WAIT_BUSY) begin n_fail++; $display("FAIL single_wait_busy: got %0d want %0d", dbg_state, ST_WAIT_BUSY); end
        tx_n_rd = 1'b1;
        tick();
        n_cmp++; if (dbg_state !== ST_WAIT_DONE) begin n_fail++; $display("FAIL single_wait_done: got %0d want %0d", dbg_state, ST_WAIT_DONE); end
        tx_n_rd = 1'b0;
        tick();
        n_cmp++; if (dbg_state !== ST_IDLE || tx_n_cs !== 1'b1) begin n_fail++; $display("FAIL single_back_idle: got st=%0d cs=%b want st=0 cs=1", dbg_state, tx_n_cs); end
    endtask

    task automatic test_round_robin;
        bit          ok;
        logic [1:0]  exp_ack;
        logic [7:0]  exp_byte;
        do_reset();
        req_data = {8'hB1, 8'hA0};
        n_req    = 2'b00;
        for (int k = 0; k < 4; k++) begin
            exp_ack  = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_byte = (k % 2 == 0) ? 8'hA0 : 8'hB1;
            wait_strobe(ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL rr_timeout_%0d: got no strobe want strobe", k); end
            n_cmp++; if (n_ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack_%0d: got %b want %b", k, n_ack, exp_ack); end
            n_cmp++; if (tx_data !== exp_byte) begin n_fail++; $display("FAIL rr_data_%0d: got %h want %h", k, tx_data, exp_byte); end
            tick();
            tx_n_rd = 1'b1;
            for (int c = 0; c < 4; c++) begin
                tick();
                n_cmp++; if (tx_n_cs !== 1'b1) begin n_fail++; $display("FAIL rr_busy_strobe_%0d: got %b want 1", k, tx_n_cs); end
            end
            tx_n_rd = 1'b0;
        end
        n_req = '1;
        tick();
        tick();
    endtask

    task automatic test_timeout;
        do_reset();
        req_data = {8'h00, 8'h77};
        n_req    = 2'b10;
        tick();
        n_cmp++; if (tx_n_cs !== 1'b0) begin n_fail++; $display("FAIL to_strobe: got %b want 0", tx_n_cs); end
        n_req = '1;
        tick();
        n_cmp++; if (dbg_state !== ST_WAIT_BUSY) begin n_fail++; $display("FAIL to_enter: got %0d want %0d", dbg_state, ST_WAIT_BUSY); end
        for (int j = 1; j < WAIT_MAX; j++) begin
            tick();
            n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_early_err_%0d: got %b want 0", j, err); end
        end
        tick();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", err); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL to_idle: got %0d want %0d", dbg_state, ST_IDLE); end
        tick();
        n_cmp++; if (err !== 1'b0 || tx_n_cs !== 1'b1) begin n_fail++; $display("FAIL to_err_len: got err=%b cs=%b want err=0 cs=1", err, tx_n_cs); end
    endtask

    task automatic test_reset_mid;
        // last winner is 0 here, so requester 1 wins first
        req_data = {8'h5A, 8'h00};
        n_req    = 2'b01;
        tick();
        n_cmp++; if (n_ack !== 2'b01 || tx_data !== 8'h5A) begin n_fail++; $display("FAIL rm_launch: got ack=%b data=%h want ack=01 data=5a", n_ack, tx_data); end
        n_req = '1;
        tick();
        tx_n_rd = 1'b1;
        tick();
        n_cmp++; if (dbg_state !== ST_WAIT_DONE) begin n_fail++; $display("FAIL rm_in_frame: got %0d want %0d", dbg_state, ST_WAIT_DONE); end
        req_data = {8'h5A, 8'h33};
        n_req    = 2'b10;
        #1 n_rst = 1'b0;
        #1;
        n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rm_async_data: got %h want 00", tx_data); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rm_async_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_cmp++; if (n_ack !== 2'b11 || tx_n_cs !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL rm_async_ctl: got ack=%b cs=%b err=%b want 11 1 0", n_ack, tx_n_cs, err); end
        #1 n_rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (tx_n_cs !== 1'b1) begin n_fail++; $display("FAIL rm_no_strobe_%0d: got %b want 1", c, tx_n_cs); end
        end
        tx_n_rd = 1'b0;
        tick();
        n_cmp++; if (tx_n_cs !== 1'b0 || n_ack !== 2'b10 || tx_data !== 8'h33) begin n_fail++; $display("FAIL rm_relaunch: got cs=%b ack=%b data=%h want 0 10 33", tx_n_cs, n_ack, tx_data); end
        n_req = '1;
        finish_frame();
    endtask

    task automatic test_idle_busy;
        // last winner is 0 here
        req_data = {8'hE5, 8'h00};
        tx_n_rd  = 1'b1;
        n_req    = 2'b01;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (tx_n_cs !== 1'b1 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL ib_hold_%0d: got cs=%b st=%0d want cs=1 st=0", c, tx_n_cs, dbg_state); end
        end
        tx_n_rd = 1'b0;
        tick();
        n_cmp++; if (tx_n_cs !== 1'b0 || n_ack !== 2'b01 || tx_data !== 8'hE5) begin n_fail++; $display("FAIL ib_launch: got cs=%b ack=%b data=%h want 0 01 e5", tx_n_cs, n_ack, tx_data); end
        n_req = '1;
        finish_frame();
    endtask

    task automatic test_drop;
        // last winner is 1, so requester 0 would normally win next
        req_data = {8'h9C, 8'h11};
        tx_n_rd  = 1'b1;
        n_req    = 2'b10;
        tick();
        n_req = 2'b01;
        tick();
        tx_n_rd = 1'b0;
        tick();
        n_cmp++; if (tx_n_cs !== 1'b0 || n_ack !== 2'b01 || tx_data !== 8'h9C) begin n_fail++; $display("FAIL drop_winner: got cs=%b ack=%b data=%h want 0 01 9c", tx_n_cs, n_ack, tx_data); end
        n_req = '1;
        finish_frame();
    endtask

`ifdef UART_ARB_LOCK_EN
    task automatic test_lock;
        bit          ok;
        logic [1:0]  exp_ack;
        logic [7:0]  exp_byte;
        do_reset();
        req_data = {8'hC1, 8'hC0};
        n_lock   = 2'b01;
        n_req    = 2'b00;
        for (int k = 0; k < 4; k++) begin
            exp_ack  = (k < 3) ? 2'b01 : 2'b10;
            exp_byte = (k < 3) ? 8'hC1 : 8'hC0;
            wait_strobe(ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL lock_timeout_%0d: got no strobe want strobe", k); end
            n_cmp++; if (n_ack !== exp_ack || tx_data !== exp_byte) begin n_fail++; $display("FAIL lock_order_%0d: got ack=%b data=%h want ack=%b data=%h", k, n_ack, tx_data, exp_ack, exp_byte); end
            if (k == 2) begin
                n_lock   = '1;
                n_req[1] = 1'b1;
            end
            if (k == 3) n_req = '1;
            finish_frame();
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_idle_busy();
        test_drop();
`ifdef UART_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
